// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one pipelined Q1.23 multiplier among NREQ requesters.
// Optional build macro MULT_SHARE_SAT_EN: saturate -1.0 * -1.0 to +1.0 (24'h7FFFFF) instead of wrapping.
module mult_share_arb #(
  parameter int W    = 24,
  parameter int NREQ = 4,
  parameter int LAT  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_a,
  input  logic [NREQ*W-1:0] i_b,
  output logic [NREQ-1:0]   o_gnt,
  output logic              o_mul_ce,
  output logic              o_mul_sclr,
  output logic [W-1:0]      o_mul_a,
  output logic [W-1:0]      o_mul_b,
  input  logic [2*W-1:0]    i_mul_p,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic [W-1:0]      o_rsp_data,
  output logic              o_busy
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         w_win;
  logic [PW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_gv;
  logic [W-1:0]          w_opa;
  logic [W-1:0]          w_opb;
  logic [LAT:0]          r_vld;
  logic [LAT:0][PW-1:0]  r_id;
  logic [W-1:0]          w_fmt;
  logic                  w_unused;

  // Rotating-priority search starting just after the last winner; the k=1 candidate is written last so it wins.
  always_comb begin
    w_win = r_ptr;
    w_idx = r_ptr;
    w_any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NREQ);
      if (i_req[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
    w_gv  = i_rst_n & i_en & ~i_clr & w_any;
    o_gnt = '0;
    w_opa = '0;
    w_opb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == w_win) begin
        o_gnt[i] = w_gv;
        w_opa    = i_a[i*W +: W];
        w_opb    = i_b[i*W +: W];
      end
    end
  end

  assign o_mul_ce   = i_en;
  assign o_mul_sclr = i_clr | ~i_rst_n;
  assign o_busy     = |r_vld;

  // The product keeps bits [2W-2:W-1]: identical to dropping the redundant sign bit for every in-range
  // product, while -1.0 * -1.0 wraps to the most negative code.
`ifdef MULT_SHARE_SAT_EN
  logic [LAT:0] r_ovf;
  logic         w_ovf;
  assign w_ovf = (w_opa == {1'b1, {(W-1){1'b0}}}) && (w_opb == {1'b1, {(W-1){1'b0}}});
  assign w_fmt = r_ovf[LAT] ? {1'b0, {(W-1){1'b1}}} : i_mul_p[2*W-2 -: W];
  // Overflow flag travels with its operation so saturation lines up with the returning product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ovf <= '0;
    else if (i_en && !i_clr) r_ovf <= {r_ovf[LAT-1:0], w_gv & w_ovf};
  end
`else
  assign w_fmt = i_mul_p[2*W-2 -: W];
`endif
  assign w_unused = &{1'b0, i_mul_p[2*W-1], i_mul_p[W-2:0]};

  // Round-robin pointer remembers the last winner; no grant leaves it alone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ptr <= PW'(NREQ - 1);
    else if (w_gv) r_ptr <= w_win;
  end

  // Operand registers feeding the multiplier load only on a grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mul_a <= '0;
      o_mul_b <= '0;
    end else if (w_gv) begin
      o_mul_a <= w_opa;
      o_mul_b <= w_opb;
    end
  end

  // ID tracker mirrors the multiplier pipeline: shifts with mul_ce, flushed by clr regardless of en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_id  <= '0;
    end else if (i_clr) begin
      r_vld <= '0;
    end else if (i_en) begin
      r_vld <= {r_vld[LAT-1:0], w_gv};
      r_id  <= {r_id[LAT-1:0], w_win};
    end
  end

  // Return the product to its owner as a one-cycle one-hot pulse; data holds between results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
    end else if (i_en && !i_clr && r_vld[LAT]) begin
      o_rsp_valid <= NREQ'(1) << r_id[LAT];
      o_rsp_data  <= w_fmt;
    end else begin
      o_rsp_valid <= '0;
    end
  end
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed test of mult_share_arb with a behavioural multiplier and result scoreboard.
module tb_mult_share_arb;
  localparam int W = 24;
  localparam int N = 4;
  localparam int LAT = 4;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] a = '0, b = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic ce, sclr, busy;
  logic [W-1:0] mul_a, mul_b, rsp_data;
  logic [2*W-1:0] mul_p;
  logic [2*W-1:0] mp [LAT];

  typedef struct {int ch; logic [W-1:0] d; int due;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_en = 0;

  always #5 clk = ~clk;

  mult_share_arb #(.W(W), .NREQ(N), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_req(req), .i_a(a), .i_b(b),
    .o_gnt(gnt), .o_mul_ce(ce), .o_mul_sclr(sclr), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_p(mul_p), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_busy(busy));

  // external multiplier: LAT register stages, gated by ce, cleared by sclr
  assign mul_p = mp[LAT-1];
  always @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else if (ce) begin
      mp[0] <= $signed(mul_a) * $signed(mul_b);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end

  function automatic logic [W-1:0] q123(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = $signed(x) * $signed(y);
`ifdef MULT_SHARE_SAT_EN
    if (x == 24'h800000 && y == 24'h800000) return 24'h7FFFFF;
`endif
    return p[46:23];
  endfunction

  task automatic chk(input string tag, input logic [47:0] o, input logic [47:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count enabled edges; an op granted with count E returns when the count reaches E+LAT+2
  always @(posedge clk) if (rst_n && en) n_en++;

  // scoreboard: compare due results, flag stray pulses, drop flushed ops, record new grants
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else if (q.size() > 0 && q[0].due == n_en) begin
      chk("rsp_valid", 48'(rsp_valid), 48'(1) << q[0].ch);
      chk("rsp_data", 48'(rsp_data), 48'(q[0].d));
      void'(q.pop_front());
    end else chk("rsp_idle", 48'(rsp_valid), 48'd0);
    if (clr || !rst_n) q.delete();
    for (int i = 0; i < N; i++)
      if (gnt[i]) q.push_back('{i, q123(a[i*W +: W], b[i*W +: W]), n_en + LAT + 2});
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 48'(gnt), 48'd0);
    chk({tag, "_mul_a"}, 48'(mul_a), 48'd0);
    chk({tag, "_mul_b"}, 48'(mul_b), 48'd0);
    chk({tag, "_rsp_valid"}, 48'(rsp_valid), 48'd0);
    chk({tag, "_rsp_data"}, 48'(rsp_data), 48'd0);
    chk({tag, "_busy"}, 48'(busy), 48'd0);
  endtask

  initial begin
    a = {24'h0C0000, 24'h7FFFFF, 24'hE00000, 24'h400000};
    b = {24'hF00000, 24'h7FFFFF, 24'h200000, 24'h600000};
    repeat (2) tick();
    en = 1'b1;
    req = '1;
    #1;
    chk_zero("reset");
    chk("reset_sclr", 48'(sclr), 48'd1);
    tick();
    // round robin from reset: ch0 first, back-to-back results
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_gnt", 48'(gnt), 48'(1) << (k % 4));
      tick();
    end
    req = '0;
    repeat (8) tick();
    // single op latency: gnt in t, result in t+LAT+2
    a[0 +: W] = 24'h400000;
    b[0 +: W] = 24'h400000;
    req = 4'b0001;
    #1;
    chk("lat_gnt", 48'(gnt), 48'h1);
    tick();
    req = '0;
    repeat (5) tick();
    #1;
    chk("lat_rsp_valid", 48'(rsp_valid), 48'h1);
    chk("lat_rsp_data", 48'(rsp_data), 48'h200000);
    repeat (2) tick();
    // stall: en low three cycles after the second grant
    a[W +: W] = 24'hA00000;
    b[W +: W] = 24'h300000;
    req = 4'b0001;
    #1;
    chk("stall_gnt0", 48'(gnt), 48'h1);
    tick();
    req = 4'b0010;
    #1;
    chk("stall_gnt1", 48'(gnt), 48'h2);
    tick();
    en = 1'b0;
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_nognt", 48'(gnt), 48'd0);
      chk("stall_busy", 48'(busy), 48'd1);
      chk("stall_ce", 48'(ce), 48'd0);
      tick();
    end
    en = 1'b1;
    #1;
    chk("stall_gnt2", 48'(gnt), 48'h4);
    tick();
    req = '0;
    repeat (10) tick();
    // flush three in-flight ops; clr beats a simultaneous request
    for (int c = 0; c < 3; c++) begin
      req = 4'(1 << c);
      #1;
      chk("flush_gnt", 48'(gnt), 48'(1) << c);
      tick();
    end
    req = 4'b1000;
    clr = 1'b1;
    #1;
    chk("flush_clr_gnt", 48'(gnt), 48'd0);
    chk("flush_busy_before", 48'(busy), 48'd1);
    chk("flush_sclr", 48'(sclr), 48'd1);
    tick();
    clr = 1'b0;
    #1;
    chk("flush_busy_after", 48'(busy), 48'd0);
    chk("flush_next_gnt", 48'(gnt), 48'h8);
    tick();
    req = '0;
    repeat (10) tick();
    // -1.0 * -1.0
    a[0 +: W] = 24'h800000;
    b[0 +: W] = 24'h800000;
    req = 4'b0001;
    #1;
    chk("minmin_gnt", 48'(gnt), 48'h1);
    tick();
    req = '0;
    repeat (5) tick();
    #1;
    chk("minmin_rsp_valid", 48'(rsp_valid), 48'h1);
`ifdef MULT_SHARE_SAT_EN
    chk("minmin_rsp_data", 48'(rsp_data), 48'h7FFFFF);
`else
    chk("minmin_rsp_data", 48'(rsp_data), 48'h800000);
`endif
    repeat (2) tick();
    // async reset in the middle of a stream
    req = '1;
    repeat (4) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("areset");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("areset_first_gnt", 48'(gnt), 48'h1);
    tick();
    req = '0;
    repeat (10) tick();
    chk("sb_empty", 48'(q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
